// File: rtl/afg_addr_gen.sv
// Phase-accumulator read-address generator for the waveform RAM: continuous or N-period burst, drain, then Done.
// First valid Addr one edge after Start; FreqReady stays low while a frequency word waits for the next period wrap.
module afg_addr_gen #(
  parameter int ACC_W     = 32,
  parameter int ADDR_W    = 14,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stop,
  input  logic [CNT_W-1:0]  BurstCount,
  input  logic [ACC_W-1:0]  FreqWord,
  input  logic              FreqValid,
  output logic              FreqReady,
  output logic [ADDR_W-1:0] Addr,
  output logic              AddrValid,
  output logic              Wrap,
  output logic              Busy,
  output logic              Done
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] freq_act;
  logic [ACC_W-1:0] pend_dat;
  logic             pend_vld;
  logic [CNT_W-1:0] cnt;
  logic [DCW-1:0]   dcnt;
  logic             carry_q;
  logic [ACC_W:0]   sum;
  logic             carry;

  assign sum   = {1'b0, acc} + {1'b0, freq_act};
  assign carry = sum[ACC_W];
  assign Busy  = (state != S_IDLE);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      freq_act  <= '0;
      pend_dat  <= '0;
      pend_vld  <= 1'b0;
      FreqReady <= 1'b1;
      cnt       <= '0;
      dcnt      <= '0;
      carry_q   <= 1'b0;
      Addr      <= '0;
      AddrValid <= 1'b0;
      Wrap      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          AddrValid <= 1'b0;
          Wrap      <= 1'b0;
          if (pend_vld) begin
            freq_act  <= pend_dat;
            pend_vld  <= 1'b0;
            FreqReady <= 1'b1;
          end
          if (Start && !Stop) begin
            acc     <= '0;
            cnt     <= BurstCount;
            carry_q <= 1'b0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          Addr      <= acc[ACC_W-1 -: ADDR_W];
          AddrValid <= 1'b1;
          Wrap      <= carry_q;
          acc       <= sum[ACC_W-1:0];
          carry_q   <= carry;
          // A new increment only takes effect at a period boundary so no period is ever distorted.
          if (carry) begin
            if (pend_vld) begin
              freq_act  <= pend_dat;
              pend_vld  <= 1'b0;
              FreqReady <= 1'b1;
            end
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
          end
          if (Stop || (carry && cnt == CNT_W'(1))) begin
            state <= S_DRAIN;
            dcnt  <= '0;
          end
        end
        S_DRAIN: begin
          AddrValid <= 1'b0;
          Wrap      <= 1'b0;
          if (dcnt == DCW'(DRAIN_CYC - 1)) begin
            state <= S_IDLE;
            Done  <= 1'b1;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      // FreqReady is low whenever pend_vld is set, so this never collides with an apply above.
      if (FreqValid && FreqReady) begin
        pend_dat  <= FreqWord;
        pend_vld  <= 1'b1;
        FreqReady <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_afg_addr_gen.sv
// Bench for afg_addr_gen: unbounded-phase reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_afg_addr_gen;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start, Stop, FreqValid, FreqReady;
  logic [15:0] BurstCount;
  logic [31:0] FreqWord;
  logic [13:0] Addr;
  logic        AddrValid, Wrap, Busy, Done;

  always #5 Clock = ~Clock;

  afg_addr_gen #(.ACC_W(32), .ADDR_W(14), .CNT_W(16), .DRAIN_CYC(3)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Stop(Stop),
    .BurstCount(BurstCount), .FreqWord(FreqWord), .FreqValid(FreqValid),
    .FreqReady(FreqReady), .Addr(Addr), .AddrValid(AddrValid), .Wrap(Wrap),
    .Busy(Busy), .Done(Done)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: total phase kept unbounded, so bits above 31 count completed periods.
  longint unsigned m_phase, m_nxt, m_last_per;
  logic [31:0]     m_freq, m_pend;
  bit              m_pend_full, m_rdy, m_busy, m_run, m_vld, m_wrap, m_done, m_xfer;
  logic [13:0]     m_addr;
  int              m_burst, m_drain_left;

  task automatic model_step();
    if (!Reset_n) begin
      m_phase = 0; m_last_per = 0; m_freq = 0; m_pend = 0; m_pend_full = 0;
      m_rdy = 1; m_busy = 0; m_run = 0; m_vld = 0; m_wrap = 0; m_done = 0;
      m_addr = 0; m_burst = 0; m_drain_left = 0;
    end else begin
      m_xfer = FreqValid && m_rdy;
      m_done = 0;
      if (!m_busy) begin
        m_vld = 0; m_wrap = 0;
        if (m_pend_full) begin m_freq = m_pend; m_pend_full = 0; m_rdy = 1; end
        if (Start && !Stop) begin
          m_busy = 1; m_run = 1; m_phase = 0; m_last_per = 0; m_burst = int'(BurstCount);
        end
      end else if (m_run) begin
        m_addr     = m_phase[31:18];
        m_vld      = 1;
        m_wrap     = (m_phase >> 32) > m_last_per;
        m_last_per = m_phase >> 32;
        m_nxt      = m_phase + longint'(m_freq);
        if ((m_nxt >> 32) != (m_phase >> 32) && m_pend_full) begin
          m_freq = m_pend; m_pend_full = 0; m_rdy = 1;
        end
        if (Stop || (m_burst != 0 && (m_nxt >> 32) == longint'(m_burst))) begin
          m_run = 0; m_drain_left = 3;
        end
        m_phase = m_nxt;
      end else begin
        m_vld = 0; m_wrap = 0;
        m_drain_left--;
        if (m_drain_left == 0) begin m_busy = 0; m_done = 1; end
      end
      if (m_xfer) begin m_pend = FreqWord; m_pend_full = 1; m_rdy = 0; end
    end
  endtask

  initial forever begin
    @(posedge Clock or negedge Reset_n);
    model_step();
  end

  initial forever begin
    @(negedge Clock);
    if (chk_en) begin
      chk("addr",  64'(Addr),      64'(m_addr));
      chk("vld",   64'(AddrValid), 64'(m_vld));
      chk("wrap",  64'(Wrap),      64'(m_wrap));
      chk("busy",  64'(Busy),      64'(m_busy));
      chk("done",  64'(Done),      64'(m_done));
      chk("rdy",   64'(FreqReady), 64'(m_rdy));
    end
  end

  logic [13:0] got_addr[$];
  bit          got_wrap[$];
  bit          got_rdy[$];
  int cyc = 0, last_vld_cyc = 0, done_cyc = 0, n_done = 0;

  initial forever begin
    @(negedge Clock);
    cyc++;
    if (AddrValid === 1'b1) begin
      got_addr.push_back(Addr);
      got_wrap.push_back(Wrap);
      got_rdy.push_back(FreqReady);
      last_vld_cyc = cyc;
    end
    if (Done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic clear_obs();
    got_addr.delete(); got_wrap.delete(); got_rdy.delete();
    n_done = 0;
  endtask

  task automatic load_freq(input logic [31:0] w);
    FreqWord = w; FreqValid = 1'b1;
    tick();
    FreqValid = 1'b0;
    chk("load_rdy_low", 64'(FreqReady), 64'd0);
    tick();
    tick();
  endtask

  task automatic start_run(input int burst);
    BurstCount = 16'(burst); Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_samples(input int n, input string nm);
    int i = 0;
    while (got_addr.size() < n && i < 400) begin tick(); i++; end
    chk(nm, 64'(got_addr.size()), 64'(n));
  endtask

  task automatic wait_done(input string nm);
    int i = 0;
    while (n_done == 0 && i < 400) begin tick(); i++; end
    tick(); tick();
    chk({nm, "_ndone"}, 64'(n_done), 64'd1);
    chk({nm, "_drain"}, 64'(done_cyc - last_vld_cyc), 64'd3);
    chk({nm, "_busy"},  64'(Busy), 64'd0);
  endtask

  function automatic int n_wraps();
    int s = 0;
    foreach (got_wrap[k]) s += int'(got_wrap[k]);
    return s;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Start = 0; Stop = 0; BurstCount = 0; FreqWord = 0; FreqValid = 0;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_addr", 64'(Addr), 64'd0);
    chk("rst_vld",  64'(AddrValid), 64'd0);
    chk("rst_rdy",  64'(FreqReady), 64'd1);
    chk("rst_busy", 64'(Busy), 64'd0);
    Reset_n = 1'b1;
    tick();

    // Burst of two periods at step 1024.
    load_freq(32'h1000_0000);
    clear_obs();
    start_run(2);
    wait_done("t2");
    chk("t2_count", 64'(got_addr.size()), 64'd32);
    chk("t2_a1",    64'(got_addr[1]),  64'd1024);
    chk("t2_a15",   64'(got_addr[15]), 64'd15360);
    chk("t2_a16",   64'(got_addr[16]), 64'd0);
    chk("t2_w16",   64'(got_wrap[16]), 64'd1);
    chk("t2_nwrap", 64'(n_wraps()),    64'd1);
    chk("t2_a31",   64'(got_addr[31]), 64'd15360);

    // Continuous at step 512, stopped on the 40th sample.
    load_freq(32'h0800_0000);
    clear_obs();
    start_run(0);
    wait_samples(39, "t3_run");
    Stop = 1'b1; tick(); Stop = 1'b0;
    wait_done("t3");
    chk("t3_count", 64'(got_addr.size()), 64'd40);
    chk("t3_a31",   64'(got_addr[31]), 64'd15872);
    chk("t3_a32",   64'(got_addr[32]), 64'd0);
    chk("t3_w32",   64'(got_wrap[32]), 64'd1);
    chk("t3_a39",   64'(got_addr[39]), 64'd3584);
    chk("t3_nwrap", 64'(n_wraps()),    64'd1);

    // Frequency update mid-period takes effect only after the wrap.
    load_freq(32'h1000_0000);
    clear_obs();
    start_run(0);
    wait_samples(5, "t4_run");
    FreqWord = 32'h2000_0000; FreqValid = 1'b1;
    tick();
    FreqValid = 1'b0;
    chk("t4_rdy_low", 64'(FreqReady), 64'd0);
    wait_samples(22, "t4_run2");
    Stop = 1'b1; tick(); Stop = 1'b0;
    wait_done("t4");
    chk("t4_count", 64'(got_addr.size()), 64'd23);
    chk("t4_a5",    64'(got_addr[5]),  64'd5120);
    chk("t4_a15",   64'(got_addr[15]), 64'd15360);
    chk("t4_a16",   64'(got_addr[16]), 64'd0);
    chk("t4_w16",   64'(got_wrap[16]), 64'd1);
    chk("t4_a17",   64'(got_addr[17]), 64'd2048);
    chk("t4_a18",   64'(got_addr[18]), 64'd4096);
    chk("t4_rdy10", 64'(got_rdy[10]),  64'd0);
    chk("t4_rdy14", 64'(got_rdy[14]),  64'd0);
    chk("t4_rdy15", 64'(got_rdy[15]),  64'd1);

    // Start with Stop in IDLE, then Start pulsed during DRAIN.
    clear_obs();
    Start = 1'b1; Stop = 1'b1; tick(); Start = 1'b0; Stop = 1'b0;
    tick(); tick();
    chk("t5_busy",  64'(Busy), 64'd0);
    chk("t5_novld", 64'(got_addr.size()), 64'd0);
    start_run(0);
    wait_samples(3, "t5_run");
    Stop = 1'b1; tick(); Stop = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    wait_done("t5b");
    repeat (4) tick();
    chk("t5_single_done", 64'(n_done), 64'd1);
    chk("t5_idle", 64'(Busy), 64'd0);

    // Near-full-scale step: carry on every add after the first.
    load_freq(32'hFFFF_FFFF);
    clear_obs();
    start_run(1);
    wait_done("t6");
    chk("t6_count", 64'(got_addr.size()), 64'd2);
    chk("t6_a0",    64'(got_addr[0]), 64'd0);
    chk("t6_a1",    64'(got_addr[1]), 64'd16383);
    chk("t6_nwrap", 64'(n_wraps()),   64'd0);

    // Asynchronous reset while running with a word pending.
    load_freq(32'h0100_0000);
    clear_obs();
    start_run(0);
    wait_samples(4, "t1_run");
    FreqWord = 32'h0200_0000; FreqValid = 1'b1;
    tick();
    FreqValid = 1'b0;
    chk("t1_rdy_pend", 64'(FreqReady), 64'd0);
    @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t1_addr", 64'(Addr), 64'd0);
    chk("t1_vld",  64'(AddrValid), 64'd0);
    chk("t1_wrap", 64'(Wrap), 64'd0);
    chk("t1_busy", 64'(Busy), 64'd0);
    chk("t1_done", 64'(Done), 64'd0);
    chk("t1_rdy",  64'(FreqReady), 64'd1);
    n_done = 0;
    repeat (2) tick();
    Reset_n = 1'b1;
    repeat (8) tick();
    chk("t1_no_done", 64'(n_done), 64'd0);
    chk("t1_idle", 64'(Busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
